// File: rtl/femto_dma_pkg.sv
// Shared types and constants for the word-copy/fill DMA engine.
package femto_dma_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
    FILL   = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [3:0] WMASK_ALL  = 4'b1111;
  localparam logic [3:0] WMASK_NONE = 4'b0000;
  localparam int         MEM_WORDS_DEFAULT = 2048;

  // True when the word span [addr>>2, addr>>2 + len) lies inside the RAM; wide enough not to wrap.
  function automatic logic span_fits(input logic [31:0] byte_addr,
                                     input logic [32:0] len,
                                     input logic [32:0] words);
    logic [33:0] sum;
    sum = {4'b0, byte_addr[31:2]} + {1'b0, len};
    return sum <= {1'b0, words};
  endfunction

endpackage

// File: rtl/mem_copy_engine.sv
// Word copy / word fill initiator on a FemtoRV-style memory port; copy 2 cycles/word, fill 1 cycle/word, done one cycle after the last write.
// No backpressure: the external arbiter must grant the port for the whole transfer; start is ignored while busy.
module mem_copy_engine
  import femto_dma_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             fill,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic [31:0]      pattern,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      mem_addr,
  output logic             mem_rstrb,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wmask,
  input  logic [31:0]      mem_rdata
);

  state_t           state;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [31:0]      pattern_q;
  logic [LEN_W-1:0] remaining;
  logic             error_q;

  logic [32:0] len_ext;
  logic        cmd_aligned;
  logic        cmd_fits;
  logic        cmd_ok;

  assign len_ext     = 33'(len_words);
  assign cmd_aligned = (dst_addr[1:0] == 2'b00) && (fill || (src_addr[1:0] == 2'b00));
  assign cmd_fits    = span_fits(dst_addr, len_ext, 33'(MEM_WORDS)) &&
                       (fill || span_fits(src_addr, len_ext, 33'(MEM_WORDS)));
  assign cmd_ok      = cmd_aligned && cmd_fits;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      pattern_q <= '0;
      remaining <= '0;
      error_q   <= 1'b0;
    end else begin
      error_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!cmd_ok) begin
              error_q <= 1'b1;
            end else begin
              src_ptr   <= src_addr;
              dst_ptr   <= dst_addr;
              pattern_q <= pattern;
              remaining <= len_words;
              if (len_words == '0)
                state <= FINISH;
              else if (fill)
                state <= FILL;
              else
                state <= READ;
            end
          end
        end
        READ: state <= WRITE;
        WRITE: begin
          src_ptr   <= src_ptr + 32'd4;
          dst_ptr   <= dst_ptr + 32'd4;
          remaining <= remaining - LEN_W'(1);
          state     <= (remaining == LEN_W'(1)) ? FINISH : READ;
        end
        FILL: begin
          dst_ptr   <= dst_ptr + 32'd4;
          remaining <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1))
            state <= FINISH;
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus side is a pure decode of registered state; only the write enable also sees reset so an aborted transfer never writes.
  assign busy      = (state == READ) || (state == WRITE) || (state == FILL);
  assign done      = (state == FINISH);
  assign error     = error_q;
  assign mem_rstrb = (state == READ);
  assign mem_wmask = (!reset && ((state == WRITE) || (state == FILL))) ? WMASK_ALL : WMASK_NONE;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      READ:  mem_addr = src_ptr;
      WRITE: begin
        mem_addr  = dst_ptr;
        mem_wdata = mem_rdata;
      end
      FILL: begin
        mem_addr  = dst_ptr;
        mem_wdata = pattern_q;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
      end
    endcase
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Bus initiator on the FemtoRV-style word memory port (mem_addr / mem_rdata / mem_rstrb / mem_wdata / mem_wmask).
- Performs word copies (src -> dst) or word fills (pattern -> dst) without CPU involvement.
- Sits beside the CPU on a memory port arbitrated outside this block; drives the same single-cycle-read, write-on-edge RAM.
- Typical uses: firmware relocation and buffer clearing.

Parameters:
- LEN_W, 16, width of the word-count input.
- MEM_WORDS, 2048, number of 32-bit words in the target RAM; used for the range check.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; honoured only in IDLE.
- fill  in  1  sampled at start: 1 = fill with pattern, 0 = copy.
- src_addr  in  32  byte address of the source, sampled at start; ignored when fill=1.
- dst_addr  in  32  byte address of the destination, sampled at start.
- len_words  in  LEN_W  number of words, sampled at start.
- pattern  in  32  fill word, sampled at start.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse at normal completion.
- error  out  1  one-cycle pulse when a command is rejected.
- mem_addr  out  32  byte address presented to memory; low 2 bits are always 0.
- mem_rstrb  out  1  read strobe.
- mem_wdata  out  32  write data.
- mem_wmask  out  4  byte write enables; 4'b1111 for a write, 4'b0000 otherwise.
- mem_rdata  in  32  read data, valid the cycle after mem_rstrb and held until the next strobe.

Behaviour:
- Reset: state IDLE; busy, done, error, mem_rstrb = 0; mem_wmask = 0; mem_addr = 0; mem_wdata = 0; internal counters = 0.
- Memory outputs are decoded from registered state, so there are no combinational paths from start to the bus.
- States:
  - IDLE, READ, WRITE, FILL, FINISH.
  - IDLE + start, command invalid -> error pulse next cycle; stay IDLE; no bus activity.
  - IDLE + start, len_words = 0 -> FINISH.
  - IDLE + start, fill = 1 -> FILL.
  - IDLE + start, otherwise -> READ.
- Invalid command means either:
  - src_addr[1:0] != 0 (copy only) or dst_addr[1:0] != 0; or
  - (addr >> 2) + len_words > MEM_WORDS, checked for dst, and for src in copy mode. The sum is computed at LEN_W+1 or wider so it cannot wrap.
- READ:
  - mem_addr = src pointer; mem_rstrb = 1; mem_wmask = 0.
  - Next state WRITE.
- WRITE:
  - mem_addr = dst pointer; mem_wdata = mem_rdata; mem_wmask = 4'b1111; mem_rstrb = 0.
  - Both pointers += 4; remaining -= 1.
  - Next state READ, or FINISH when remaining reaches 0.
- FILL:
  - mem_addr = dst pointer; mem_wdata = pattern register; mem_wmask = 4'b1111 every cycle.
  - dst pointer += 4; remaining -= 1.
  - Next state FINISH when remaining reaches 0.
- FINISH: done = 1 for one cycle; busy = 0 from this cycle; next state IDLE.
- Throughput:
  - Copy: 2 cycles per word; first read in the cycle after start; done at cycle 2N+1 after start.
  - Fill: 1 cycle per word; done at cycle N+1.
- Ordering: always ascending addresses.
  - Overlap with dst > src is defined to propagate the copied value ("smear").
  - dst == src is a harmless rewrite.
- start while busy: ignored. Command inputs are not re-sampled and no error is raised.
- reset mid-operation: the next edge forces IDLE. mem_wmask = 0 from that cycle, so no partial-word write follows the reset edge. The transfer is abandoned with no done pulse.
- done and error are never high in the same cycle.
- busy is high only in READ, WRITE and FILL.

Decomposition:
- Shared package femto_dma_pkg:
  - state enum (IDLE, READ, WRITE, FILL, FINISH);
  - WMASK_ALL = 4'b1111, WMASK_NONE = 4'b0000;
  - default MEM_WORDS.
- A single module is sufficient. No sub-module: the pointer/counter datapath is small.

Test Plan:
- Copy, src=0x100, dst=0x200, len=4, RAM preloaded with 0xA0..0xA3 -> words 0x200..0x20C = 0xA0..0xA3; done exactly 9 cycles after start; exactly 4 rstrb and 4 write cycles.
- Fill, dst=0x40, len=3, pattern=0xDEADBEEF -> 0x40, 0x44, 0x48 = 0xDEADBEEF; 0x4C unchanged; done at cycle 4.
- len=0 -> no rstrb, no wmask; done the cycle after start; busy never high.
- Rejections, each giving an error pulse, no bus activity and no done:
  - dst=0x202;
  - dst=0x1FFC, len=2 with MEM_WORDS=2048 (0x7FF + 2 > 2048).
- Reset asserted during the 3rd WRITE of a len=8 copy -> wmask=0 from the next cycle; only words 0..1 written; busy=0; no done.
- Overlap copy src=0x0, dst=0x4, len=3, RAM[0..3]=1,2,3,4 -> RAM[1..3]=1,1,1; start pulsed while busy -> ignored with no error.
